elastic_pipe_stage: RTL and testbench

//  Parametrised, generic inter-stage register for the MIPS pipeline; replaces the hand-written per-stage latches (ID/EX, EX/MEM, MEM/WB).

---
 rtl/elastic_pipe_stage_pkg.sv | 30 +++
 rtl/elastic_pipe_stage_sat_counter.sv | 24 ++
 rtl/elastic_pipe_stage.sv | 151 +++++++++++++++
 tb/tb_elastic_pipe_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elastic_pipe_stage_pkg.sv
// Shared definitions for the generic inter-stage pipeline register:
// occupancy state encoding and the EX/MEM control-field bit layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // EX/MEM control field layout, shared by every stage that packs/unpacks it
  localparam int unsigned EXMEM_MEMREAD      = 0;
  localparam int unsigned EXMEM_MEMWRITE     = 1;
  localparam int unsigned EXMEM_MEMTOREG_LSB = 2;
  localparam int unsigned EXMEM_MEMTOREG_W   = 2;
  localparam int unsigned EXMEM_REGWRITE     = 4;
  localparam int unsigned EXMEM_LOADBYTE     = 5;
  localparam int unsigned EXMEM_LOAD         = 6;
  localparam int unsigned EXMEM_CTRL_W       = 7;

  // Number of entries held in a given state
  function automatic logic [1:0] occ_of(state_t s);
    case (s)
      ST_ONE:  occ_of = 2'd1;
      ST_FULL: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/elastic_pipe_stage_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Count up on inc, stick at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/elastic_pipe_stage.sv
// Generic inter-stage pipeline register with valid/ready handshake,
// synchronous flush, optional 2-entry skid buffer and a stall counter.
module elastic_pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 96,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic w_stall;

  if (SKID != 0) begin : g_skid

    state_t            r_state;
    state_t            w_next;
    logic              r_in_ready;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic              w_push;
    logic              w_pop;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = (r_state != ST_EMPTY) & out_ready;

    // Occupancy transitions; flush overrides everything
    always_comb begin
      w_next = r_state;
      if (flush) begin
        w_next = ST_EMPTY;
      end else begin
        case (r_state)
          ST_EMPTY: if (w_push) w_next = ST_ONE;
          ST_ONE: begin
            if (w_push && !w_pop)      w_next = ST_FULL;
            else if (w_pop && !w_push) w_next = ST_EMPTY;
          end
          ST_FULL:  if (w_pop) w_next = ST_ONE;
          default:  w_next = ST_EMPTY;
        endcase
      end
    end

    // State register; in_ready is registered from the next state
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state    <= ST_EMPTY;
        r_in_ready <= 1'b0;
      end else begin
        r_state    <= w_next;
        r_in_ready <= (w_next != ST_FULL);
      end
    end

    // Main/skid payload registers; main is always the head entry
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_main_ctrl <= '0;
        r_main_data <= '0;
        r_skid_ctrl <= '0;
        r_skid_data <= '0;
      end else if (flush) begin
        r_skid_ctrl <= '0;
        r_skid_data <= '0;
      end else if (w_push && ((r_state == ST_EMPTY) || w_pop)) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else if (w_push) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end else if (w_pop && (r_state == ST_FULL)) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_ctrl  = out_valid ? r_main_ctrl : '0;
    assign out_data  = r_main_data;
    assign occupancy = occ_of(r_state);

  end else begin : g_single

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic              w_push;

    assign in_ready = ~r_valid | out_ready;
    assign w_push   = in_valid & in_ready;

    // Single register: push (with or without pop) reloads, lone pop empties
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
        r_data  <= '0;
      end else if (flush) begin
        r_valid <= 1'b0;
      end else if (w_push) begin
        r_valid <= 1'b1;
        r_ctrl  <= in_ctrl;
        r_data  <= in_data;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end

    assign out_valid = r_valid;
    assign out_ctrl  = r_valid ? r_ctrl : '0;
    assign out_data  = r_data;
    assign occupancy = {1'b0, r_valid};

  end

  assign w_stall = out_valid & ~out_ready;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall),
    .count (stall_cnt)
  );

  // Upstream must hold a refused entry stable until it is accepted
  property p_in_hold;
    @(posedge clk) disable iff (reset)
      (in_valid && !in_ready && !flush) |=>
        (in_valid && $stable(in_ctrl) && $stable(in_data));
  endproperty
  a_in_hold: assert property (p_in_hold);

endmodule

// File: tb/tb_elastic_pipe_stage.sv
// Scoreboard bench: lane 0 = SKID=1/CNT_W=16, lane 1 = SKID=0/CNT_W=4.
module tb_elastic_pipe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        iv [2];
  logic        ir [2];
  logic [7:0]  ic [2];
  logic [95:0] id [2];
  logic        ov [2];
  logic        ordy [2];
  logic [7:0]  oc [2];
  logic [95:0] od [2];
  logic [1:0]  occ [2];
  logic [15:0] sc0;
  logic [3:0]  sc1;

  int n_chk  = 0;
  int n_fail = 0;
  int rel    = 0;

  logic [103:0] sb [2][$];
  int unsigned  stall_m [2];
  logic [95:0]  last_d [2];

  always #5 clk = ~clk;

  elastic_pipe_stage #(.CTRL_W(8), .DATA_W(96), .SKID(1), .CNT_W(16)) dut_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_ctrl(ic[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_ctrl(oc[0]), .out_data(od[0]),
    .occupancy(occ[0]), .stall_cnt(sc0)
  );

  elastic_pipe_stage #(.CTRL_W(8), .DATA_W(96), .SKID(0), .CNT_W(4)) dut_single (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_ctrl(ic[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_ctrl(oc[1]), .out_data(od[1]),
    .occupancy(occ[1]), .stall_cnt(sc1)
  );

  task automatic chk(input int k, input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges seen since reset release
  always @(posedge clk or posedge reset) begin
    if (reset) rel = 0;
    else       rel = rel + 1;
  end

  // Monitor: reference model is an ordered queue of accepted entries
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [15:0]  scv;
      int unsigned  mx;
      logic [103:0] e;
      scv = (k == 0) ? sc0 : {12'd0, sc1};
      mx  = (k == 0) ? 65535 : 15;
      if (reset) begin
        sb[k].delete();
        stall_m[k] = 0;
        last_d[k]  = '0;
        chk(k, "rst_valid", ov[k], 0);
        chk(k, "rst_ctrl", oc[k], 0);
        chk(k, "rst_occ", occ[k], 0);
        chk(k, "rst_stall", scv, 0);
      end else begin
        chk(k, "occupancy", occ[k], sb[k].size());
        chk(k, "out_valid", ov[k], sb[k].size() != 0);
        chk(k, "stall_cnt", scv, stall_m[k]);
        if (!ov[k]) begin
          chk(k, "bubble_ctrl", oc[k], 0);
          chk(k, "held_data", od[k], last_d[k]);
        end
        if (k == 0) begin
          if (rel >= 1) chk(k, "in_ready_reg", ir[0], sb[0].size() < 2);
        end else begin
          chk(k, "in_ready_comb", ir[1], (sb[1].size() == 0) || ordy[1]);
        end
        if (ov[k] && !ordy[k] && stall_m[k] < mx) stall_m[k]++;
        if (ov[k] && ordy[k]) begin
          if (sb[k].size() == 0) begin
            chk(k, "pop_unexpected", 1, 0);
          end else begin
            e = sb[k].pop_front();
            chk(k, "pop_ctrl", oc[k], e[103:96]);
            chk(k, "pop_data", od[k], e[95:0]);
          end
        end
        if (flush) begin
          sb[k].delete();
        end else begin
          if (iv[k] && ir[k]) sb[k].push_back({ic[k], id[k]});
          if (sb[k].size() > 0) last_d[k] = sb[k][0][95:0];
        end
      end
    end
  end

  // Present one entry and wait (bounded) for it to be accepted
  task automatic push_one(input int k, input logic [7:0] c, input logic [95:0] d, output int waited);
    bit acc;
    acc    = 1'b0;
    waited = 0;
    iv[k]  = 1'b1;
    ic[k]  = c;
    id[k]  = d;
    while (!acc) begin
      @(negedge clk);
      acc = ir[k] && !flush;
      tick();
      if (!acc) begin
        waited++;
        if (waited > 64) begin
          chk(k, "push_timeout", 0, 1);
          break;
        end
      end
    end
  endtask

  task automatic rand_lane(input int k, input int n);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!iv[k] || acc) begin
        iv[k] = ($urandom % 4) != 0;
        ic[k] = 8'($urandom);
        id[k] = {$urandom, $urandom, $urandom};
      end
      ordy[k] = ($urandom % 3) != 0;
      if (k == 0) flush = ($urandom % 24) == 0;
      @(negedge clk);
      acc = iv[k] && ir[k];
      tick();
    end
    iv[k]   = 1'b0;
    ordy[k] = 1'b1;
    if (k == 0) flush = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    logic [15:0] base;
    reset = 1'b1;
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ic[k] = '0; id[k] = '0; ordy[k] = 1'b1;
    end
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk(0, "ready_after_release", ir[0], 1);

    // Streaming 1..8 back-to-back
    for (int i = 1; i <= 8; i++) begin
      push_one(0, 8'(i), 96'(i), w);
      chk(0, "stream_wait", w, 0);
    end
    iv[0] = 1'b0;
    chk(0, "stream_last_valid", ov[0], 1);
    chk(0, "stream_last_data", od[0], 96'd8);
    tick();

    // Bubble zeroing
    push_one(0, 8'hFF, 96'hABC, w);
    iv[0] = 1'b0;
    tick();
    chk(0, "bubble_valid", ov[0], 0);
    chk(0, "bubble_ctrl_zero", oc[0], 0);
    chk(0, "bubble_data_held", od[0], 96'hABC);

    // Back-pressure A,B,C
    base = sc0;
    ordy[0] = 1'b0;
    iv[0] = 1'b1; ic[0] = 8'hA1; id[0] = 96'hA;
    tick();
    ic[0] = 8'hB2; id[0] = 96'hB;
    tick();
    chk(0, "bp_occ_full", occ[0], 2);
    chk(0, "bp_ready_low", ir[0], 0);
    ic[0] = 8'hC3; id[0] = 96'hC;
    tick();
    tick();
    chk(0, "bp_stall3", sc0, base + 16'd3);
    ordy[0] = 1'b1;
    push_one(0, 8'hC3, 96'hC, w);
    iv[0] = 1'b0;
    repeat (4) tick();

    // Flush with two held entries and a refused input
    ordy[0] = 1'b0;
    push_one(0, 8'h11, 96'h111, w);
    push_one(0, 8'h22, 96'h222, w);
    iv[0] = 1'b1; ic[0] = 8'h33; id[0] = 96'h333;
    flush = 1'b1;
    tick();
    flush = 1'b0; iv[0] = 1'b0;
    chk(0, "flush_valid", ov[0], 0);
    chk(0, "flush_ctrl", oc[0], 0);
    chk(0, "flush_occ", occ[0], 0);
    ordy[0] = 1'b1;
    repeat (3) tick();

    // Flush with a completed input handshake in the same cycle
    ordy[0] = 1'b0;
    push_one(0, 8'h44, 96'h444, w);
    iv[0] = 1'b1; ic[0] = 8'h55; id[0] = 96'h555;
    flush = 1'b1;
    tick();
    flush = 1'b0; iv[0] = 1'b0;
    chk(0, "flush_hs_occ", occ[0], 0);
    chk(0, "flush_hs_valid", ov[0], 0);
    ordy[0] = 1'b1;
    repeat (3) tick();

    // Reset mid-stream with occupancy 2
    ordy[0] = 1'b0;
    push_one(0, 8'h66, 96'h666, w);
    push_one(0, 8'h77, 96'h777, w);
    iv[0] = 1'b0;
    chk(0, "pre_reset_occ", occ[0], 2);
    reset = 1'b1;
    #1;
    chk(0, "async_rst_valid", ov[0], 0);
    chk(0, "async_rst_ctrl", oc[0], 0);
    chk(0, "async_rst_occ", occ[0], 0);
    chk(0, "async_rst_stall", sc0, 0);
    ordy[0] = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk(0, "ready_after_rst", ir[0], 1);

    // Saturation on the 4-bit counter, then combinational in_ready
    ordy[1] = 1'b0;
    push_one(1, 8'h5A, 96'h5A5, w);
    iv[1] = 1'b0;
    repeat (20) tick();
    chk(1, "stall_saturated", sc1, 4'd15);
    ordy[1] = 1'b1;
    #1;
    chk(1, "comb_ready_hi", ir[1], 1);
    ordy[1] = 1'b0;
    #1;
    chk(1, "comb_ready_lo", ir[1], 0);
    ordy[1] = 1'b1;
    tick();
    chk(1, "stall_sticks", sc1, 4'd15);

    // Randomized traffic on both lanes
    fork
      rand_lane(0, 400);
      rand_lane(1, 400);
    join
    repeat (6) tick();
    chk(0, "drain_empty", sb[0].size(), 0);
    chk(1, "drain_empty", sb[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
